encoder_bcd_key: RTL and testbench
==================================

// Module: encoder_bcd_key
//
// PURPOSE
// Converts nine debounced key lines d1..d9 into a 4-bit BCD code {a,b,c,d}, the inverse of decoder_bcd.
// Synchronises the asynchronous keys and accepts a key only after it is stable for DEBOUNCE_CYCLES.
// Raises a one-cycle valid strobe per accepted press and flags multi-key presses.
// Sits between the front-panel keypad and any logic consuming BCD digits, such as decoder_bcd.
//
// PARAMETERS
// DEBOUNCE_CYCLES  4  consecutive synced cycles a single key (or all-released) must be stable; legal range 2..7
// CNT_W            3  debounce counter width; must satisfy 2**CNT_W > DEBOUNCE_CYCLES
//
// PORTS
// clk    in   1  rising-edge clock
// rst    in   1  asynchronous, active-high reset
// d1..d9 in   1  key lines (9 ports), active-high, asynchronous to clk
// a      out  1  BCD bit 3 (MSB) of last accepted key
// b      out  1  BCD bit 2
// c      out  1  BCD bit 1
// d      out  1  BCD bit 0 (LSB)
// valid  out  1  one-cycle strobe: {a,b,c,d} updated this cycle
// multi  out  1  registered; high while more than one synced key is high
//
// BEHAVIOUR
// - Reset is asynchronous: it clears the synchronisers, sets state=IDLE and cnt=0, and drives {a,b,c,d}=0000, valid=0 and multi=0.
// - Sync: a 2-flop synchroniser on the 9-bit key vector k[9:1]. FSM and multi see only synced values.
// - Encode (combinational, on the synced vector):
//   - exactly one bit kN set -> code=N (1..9), single=1
//   - none set -> none=1
//   - two or more set -> many=1
// - multi <= many every cycle, independent of the FSM.
// - FSM states: IDLE, DEBOUNCE, HELD, RELEASE.
//   - IDLE: if single, cand<=code, cnt<=1, go to DEBOUNCE. Otherwise stay.
//   - DEBOUNCE:
//     - single and code==cand, cnt<DEBOUNCE_CYCLES-1: cnt++.
//     - single and code==cand, cnt==DEBOUNCE_CYCLES-1: {a,b,c,d}<=cand, valid<=1, go to HELD.
//     - anything else (other key, none, many): cnt<=0, go to IDLE, no strobe.
//   - HELD:
//     - none: cnt<=1, go to RELEASE.
//     - any other pattern (rollover, multi): stay. No new strobe.
//   - RELEASE:
//     - none, cnt==DEBOUNCE_CYCLES-1: cnt<=0, go to IDLE.
//     - none, lower cnt: cnt++.
//     - any key high: go to HELD (release bounce is ignored).
// - valid is high for exactly one cycle per accepted press and is never high in two consecutive cycles.
// - {a,b,c,d} changes only in the cycle valid is high, otherwise it holds.
//   - 0000 means no key accepted since reset. Codes 1010..1111 are never produced.
// - Latency: a key first sampled high at rising edge 1 drives valid high after edge 2+DEBOUNCE_CYCLES (edge 6 at default).
// - Reset mid-debounce or mid-hold aborts with no strobe. A key still held after reset must complete a full debounce from IDLE.
// - Counter never wraps: it is bounded by DEBOUNCE_CYCLES-1 and cleared on every exit.
//
// STRUCTURE
// - Shared package encoder_bcd_pkg:
//   - state typedef {IDLE, DEBOUNCE, HELD, RELEASE}
//   - NUM_KEYS=9, BCD_W=4
//   - function onehot_to_bcd(9-bit) returning {code, single, none, many}
// - One sub-module: sync_2ff, parameterised WIDTH=9, async active-high reset to 0.
// - Top level holds the encoder, FSM, counter and output registers only.
//
// TESTING (DEBOUNCE_CYCLES=4)
// 1. Assert rst between clock edges mid-press -> {a,b,c,d}=0000, valid=0 and multi=0 immediately, without waiting for a clock edge.
// 2. Hold d5 for 20 cycles, then release -> a single valid pulse after edge 6 with {a,b,c,d}=0101; value holds after release.
// 3. Pulse d3 for 3 cycles, then low -> no valid; code unchanged.
// 4. Hold d2 and d7 together for 10 cycles -> multi=1 from edge 3 until 2 cycles after release; no valid.
// 5. Press d9 (accepted, 1001), add d1 while held, then release both for 4+ cycles, then press d1 -> exactly one more valid with 0001.
// 6. Accept d4, drop it for 2 cycles, reassert -> no second valid. Assert rst during DEBOUNCE of d6 -> no valid until a full re-debounce after reset.
// 7. Sweep d1..d9 with full press/release each -> codes 0001..1001; feeding them through decoder_bcd reproduces the matching dN one-hot output.

Source files
------------

// File: rtl/encoder_bcd_pkg.sv
// Shared types and helpers for the BCD key encoder.
// Latency: n/a (types, constants and one combinational function).
// Backpressure: n/a.
//
// Contents:
//   NUM_KEYS, BCD_W   key-vector width and BCD code width
//   state_t           debounce FSM states
//   enc_t             classification of a key vector {code, single, none, many}
//   onehot_to_bcd()   classify a key vector; bit i of the vector is key d(i+1)
package encoder_bcd_pkg;

  localparam int NUM_KEYS = 9;
  localparam int BCD_W    = 4;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } state_t;

  typedef struct packed {
    logic [BCD_W-1:0] code;    // 1..9 when single, 0 otherwise
    logic             single;  // exactly one key high
    logic             none;    // no key high
    logic             many;    // two or more keys high
  } enc_t;

  // Popcount plus position of the highest set bit. The code is only
  // meaningful when exactly one bit is set, so it is forced to zero
  // otherwise to keep downstream comparisons clean.
  function automatic enc_t onehot_to_bcd(input logic [NUM_KEYS-1:0] keys);
    enc_t       r;
    logic [3:0] ones;
    r    = '0;
    ones = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (keys[i]) begin
        ones   = ones + 4'd1;
        r.code = BCD_W'(i + 1);
      end
    end
    r.none   = (ones == 4'd0);
    r.single = (ones == 4'd1);
    r.many   = (ones > 4'd1);
    if (!r.single) begin
      r.code = '0;
    end
    return r;
  endfunction

endpackage

// File: rtl/encoder_bcd_key_sync_2ff.sv
// Two-flop synchroniser for a vector of asynchronous level signals.
// Latency: 2 clk edges from input change to sync_o change.
// Backpressure: none; each bit is sampled every cycle.
//
// Ports:
//   clk     rising-edge clock
//   rst     asynchronous active-high reset, clears both stages to 0
//   async_i asynchronous input vector
//   sync_o  synchronised copy of async_i
module sync_2ff #(
  parameter int WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] async_i,
  output logic [WIDTH-1:0] sync_o
);

  logic [WIDTH-1:0] meta_q;
  logic [WIDTH-1:0] sync_q;

  // Bits are synchronised independently; keys pressed together may appear
  // a cycle apart, which the debounce FSM tolerates by restarting.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= '0;
      sync_q <= '0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  assign sync_o = sync_q;

endmodule

// File: rtl/encoder_bcd_key.sv
// Debounced 9-key to BCD encoder with one-cycle valid strobe and multi-key flag.
// Latency: key first sampled at edge 1 gives valid after edge 2+DEBOUNCE_CYCLES.
// Backpressure: none; valid is a strobe and the code register holds until the next press.
//
// Ports:
//   clk          rising-edge clock
//   rst          asynchronous active-high reset
//   d1..d9       active-high key lines, asynchronous to clk
//   a,b,c,d      BCD code of the last accepted key (a = MSB), 0000 until first press
//   valid        one-cycle strobe, high in the cycle {a,b,c,d} is updated
//   multi        registered flag, high while two or more synced keys are high
module encoder_bcd_key
  import encoder_bcd_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4,  // legal 2..7
  parameter int CNT_W           = 3   // 2**CNT_W > DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic d1,
  input  logic d2,
  input  logic d3,
  input  logic d4,
  input  logic d5,
  input  logic d6,
  input  logic d7,
  input  logic d8,
  input  logic d9,
  output logic a,
  output logic b,
  output logic c,
  output logic d,
  output logic valid,
  output logic multi
);

  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // ---------------------------------------------------------------------------
  // Synchronise and classify the key vector
  // ---------------------------------------------------------------------------
  logic [NUM_KEYS-1:0] key_raw;
  logic [NUM_KEYS-1:0] key_sync;
  enc_t                enc;

  assign key_raw = {d9, d8, d7, d6, d5, d4, d3, d2, d1};

  sync_2ff #(
    .WIDTH(NUM_KEYS)
  ) u_sync (
    .clk    (clk),
    .rst    (rst),
    .async_i(key_raw),
    .sync_o (key_sync)
  );

  assign enc = onehot_to_bcd(key_sync);

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q,   cnt_d;
  logic [BCD_W-1:0]   cand_q,  cand_d;
  logic [BCD_W-1:0]   code_q,  code_d;
  logic               valid_q, valid_d;
  logic               multi_q;
  logic               accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
      multi_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      code_q  <= code_d;
      valid_q <= valid_d;
      multi_q <= enc.many;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // cnt counts synced cycles of a stable pattern, starting at 1 on the
  // cycle that enters DEBOUNCE/RELEASE. It saturates at CNT_LAST by leaving
  // the state on that cycle, and every exit clears it, so it never wraps.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    accept  = 1'b0;

    case (state_q)
      IDLE: begin
        if (enc.single) begin
          cand_d  = enc.code;
          cnt_d   = CNT_ONE;
          state_d = DEBOUNCE;
        end else begin
          cnt_d   = '0;
        end
      end

      DEBOUNCE: begin
        if (enc.single && (enc.code == cand_q)) begin
          if (cnt_q == CNT_LAST) begin
            accept  = 1'b1;
            cnt_d   = '0;
            state_d = HELD;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          // Bounce, a different key or a chord: abandon without a strobe.
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      HELD: begin
        // Rollover and chords are ignored until every key is released.
        if (enc.none) begin
          cnt_d   = CNT_ONE;
          state_d = RELEASE;
        end
      end

      RELEASE: begin
        if (enc.none) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d   = cnt_q + CNT_ONE;
          end
        end else begin
          // Release bounce: treat the key as still held.
          cnt_d   = '0;
          state_d = HELD;
        end
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output logic
  // ---------------------------------------------------------------------------
  // accept can only fire from DEBOUNCE and always lands in HELD, so valid
  // can never be high on two consecutive cycles.
  always_comb begin
    valid_d = accept;
    code_d  = code_q;
    if (accept) begin
      code_d = cand_q;
    end
  end

  assign {a, b, c, d} = code_q;
  assign valid        = valid_q;
  assign multi        = multi_q;

endmodule

// File: tb/tb_encoder_bcd_key.sv
// Directed self-checking bench for encoder_bcd_key at DEBOUNCE_CYCLES=4.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
// Table of press/release records plus hand-written multi-cycle sequences.
module tb_encoder_bcd_key;

  logic       clk;
  logic       rst;
  logic [8:0] keys;
  logic       a, b, c, d, valid, multi;

  encoder_bcd_key #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .d1   (keys[0]),
    .d2   (keys[1]),
    .d3   (keys[2]),
    .d4   (keys[3]),
    .d5   (keys[4]),
    .d6   (keys[5]),
    .d7   (keys[6]),
    .d8   (keys[7]),
    .d9   (keys[8]),
    .a    (a),
    .b    (b),
    .c    (c),
    .d    (d),
    .valid(valid),
    .multi(multi)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int         tests = 0;
  int         fails = 0;

  // Per-phase observation statistics
  int         pulses;
  int         consec_err;
  int         chg_err;
  int         edge_n;
  int         first_valid;
  logic       multi_seen;
  logic       prev_valid;
  logic [3:0] prev_code;

  typedef struct {
    logic [8:0] keys;
    int         hold;
    int         rel;
    int         exp_pulses;
    logic [3:0] exp_code;
    logic       exp_multi;
    string      name;
  } vec_t;

  vec_t tbl[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic clear_stats();
    pulses      = 0;
    consec_err  = 0;
    chg_err     = 0;
    edge_n      = 0;
    first_valid = 0;
    multi_seen  = 1'b0;
    prev_valid  = valid;
    prev_code   = {a, b, c, d};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    edge_n++;
    if (valid) begin
      pulses++;
      if (first_valid == 0) first_valid = edge_n;
      if (prev_valid) consec_err++;
    end
    if (({a, b, c, d} !== prev_code) && !valid) chg_err++;
    if (multi) multi_seen = 1'b1;
    prev_valid = valid;
    prev_code  = {a, b, c, d};
  endtask

  task automatic run(input logic [8:0] k, input int n);
    keys = k;
    repeat (n) tick();
  endtask

  // Reference decoder_bcd: BCD 1..9 to one-hot d1..d9.
  function automatic logic [8:0] dec_bcd(input logic [3:0] code);
    logic [8:0] r;
    r = '0;
    if (code >= 4'd1 && code <= 4'd9) r[code - 4'd1] = 1'b1;
    return r;
  endfunction

  task automatic add(input logic [8:0] k, input int h, input int r, input int p,
                     input logic [3:0] code, input logic m, input string nm);
    vec_t v;
    v.keys = k; v.hold = h; v.rel = r; v.exp_pulses = p;
    v.exp_code = code; v.exp_multi = m; v.name = nm;
    tbl.push_back(v);
  endtask

  initial begin
    // Records run back to back; the code register carries over between them.
    add(9'h010, 20, 8, 1, 4'd5, 1'b0, "d5_hold20");
    add(9'h004,  3, 8, 0, 4'd5, 1'b0, "d3_pulse3");
    add(9'h042, 10, 8, 0, 4'd5, 1'b1, "d2_d7_chord");
    add(9'h004,  4, 8, 1, 4'd3, 1'b0, "d3_pulse4");
    for (int n = 1; n <= 9; n++) begin
      logic [8:0] k;
      k = 9'h001 << (n - 1);
      add(k, 6, 8, 1, 4'(n), 1'b0, $sformatf("sweep_d%0d", n));
    end

    // Reset state
    rst  = 1'b1;
    keys = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_outputs", {26'd0, a, b, c, d, valid, multi}, 32'd0);
    rst = 1'b0;
    repeat (2) tick();

    // Acceptance latency: d5 first sampled at edge 1 -> valid after edge 6
    clear_stats();
    run(9'h010, 20);
    check("lat_first_valid_edge", first_valid, 6);
    check("lat_pulses", pulses, 1);
    check("lat_code", {a, b, c, d}, 4'd5);
    run(9'h000, 8);
    check("lat_pulses_after_release", pulses, 1);
    check("lat_code_holds", {a, b, c, d}, 4'd5);

    // Multi flag timing: keys high at edges 1..10, low from edge 11
    clear_stats();
    keys = 9'h042;
    tick(); tick();
    check("multi_edge2", multi, 1'b0);
    tick();
    check("multi_edge3", multi, 1'b1);
    repeat (7) tick();
    keys = 9'h000;
    tick();
    check("multi_edge11", multi, 1'b1);
    tick();
    check("multi_edge12", multi, 1'b1);
    tick();
    check("multi_edge13", multi, 1'b0);
    check("multi_no_valid", pulses, 0);
    run(9'h000, 5);

    // Table-driven press/release records
    foreach (tbl[i]) begin
      clear_stats();
      run(tbl[i].keys, tbl[i].hold);
      run(9'h000, tbl[i].rel);
      check({tbl[i].name, "_pulses"}, pulses, tbl[i].exp_pulses);
      check({tbl[i].name, "_code"}, {a, b, c, d}, tbl[i].exp_code);
      check({tbl[i].name, "_multi"}, multi_seen, tbl[i].exp_multi);
      check({tbl[i].name, "_consec"}, consec_err, 0);
      check({tbl[i].name, "_code_chg"}, chg_err, 0);
      if (tbl[i].exp_pulses == 1)
        check({tbl[i].name, "_decode"}, dec_bcd({a, b, c, d}), tbl[i].keys);
    end

    // Rollover: d9 accepted, d1 added while held, both released, then d1
    clear_stats();
    run(9'h100, 8);
    check("roll_d9_code", {a, b, c, d}, 4'd9);
    run(9'h101, 6);
    check("roll_multi_seen", multi_seen, 1'b1);
    run(9'h000, 8);
    run(9'h001, 8);
    run(9'h000, 8);
    check("roll_pulses", pulses, 2);
    check("roll_d1_code", {a, b, c, d}, 4'd1);
    check("roll_consec", consec_err, 0);

    // Release bounce: d4 accepted, dropped for 2 cycles, reasserted
    clear_stats();
    run(9'h008, 8);
    run(9'h000, 2);
    run(9'h008, 10);
    run(9'h000, 8);
    check("bounce_pulses", pulses, 1);
    check("bounce_code", {a, b, c, d}, 4'd4);

    // Asynchronous reset mid-hold with multi high
    run(9'h010, 8);
    run(9'h090, 4);
    check("prerst_multi", multi, 1'b1);
    check("prerst_code", {a, b, c, d}, 4'd5);
    #3;
    rst = 1'b1;
    #1;
    check("async_rst_code", {a, b, c, d}, 4'd0);
    check("async_rst_valid", valid, 1'b0);
    check("async_rst_multi", multi, 1'b0);
    keys = 9'h000;
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_stats();
    run(9'h000, 6);

    // Reset during debounce of d6, key held through and after reset
    clear_stats();
    run(9'h020, 4);
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
    tick();
    tick();
    check("rst_debounce_no_valid", pulses, 0);
    rst = 1'b0;
    clear_stats();
    run(9'h020, 10);
    check("redebounce_first_valid", first_valid, 6);
    check("redebounce_pulses", pulses, 1);
    check("redebounce_code", {a, b, c, d}, 4'd6);
    run(9'h000, 8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
